alarm_fsm: RTL and testbench
============================

// Module: alarm_fsm
// PURPOSE
//  Vehicle anti-theft controller; directly upstream of the countdown timer (timer).
//  Owns the four programmable delays, drives the timer's start pulse and 4-bit load value,
//  and consumes the timer's expired pulse.
//  Produces siren, status LED and an encoded state for debug display.
// PARAMETERS
//  BLINK_HALF    26'd52_000_000  clk cycles per status_led half-period in ARMED (0.5 s at 104 MHz)
//  T_ARM_DEF     4'd6            reset value of ARM_DELAY time (s)
//  T_DRIVER_DEF  4'd8            reset value of driver-door delay (s)
//  T_PASS_DEF    4'd15           reset value of passenger-door delay (s)
//  T_ALARM_DEF   4'd10           reset value of alarm-on hold time (s)
// PORTS
//  clk_104mhz      in   1  system clock
//  reset           in   1  asynchronous, active-high reset
//  ignition        in   1  ignition switch; debounced, synchronous to clk_104mhz
//  driver_door     in   1  1 = driver door open; debounced, synchronous
//  passenger_door  in   1  1 = passenger door open; debounced, synchronous
//  reprogram       in   1  1-cycle pulse: commit prog write (if prog_we) and force ARMED
//  prog_we         in   1  write enable; sampled only with reprogram
//  prog_sel        in   2  0 = arm, 1 = driver, 2 = passenger, 3 = alarm
//  prog_val        in   4  new time (s); 0 is legal
//  expired         in   1  1-cycle pulse from the timer
//  start_timer     out  1  registered 1-cycle pulse to the timer
//  value           out  4  registered load value; valid in the cycle start_timer = 1
//  siren           out  1  registered
//  status_led      out  1  registered
//  state_out       out  3  current state encoding (list below)
// BEHAVIOUR
//  Reset (async): state ARMED, start_timer 0, value 0, siren 0, status_led 0, blink counter 0,
//   time registers <- *_DEF.
//  States: 0 ARMED, 1 TRIGGERED, 2 SOUND_ALARM, 3 ALARM_HOLD, 4 DISARMED, 5 WAIT_DOOR_OPEN,
//   6 WAIT_DOOR_CLOSE, 7 ARM_DELAY.
//  "Start T" = on the transition edge: start_timer <= 1, value <= T; next cycle start_timer <= 0.
//  expired is ignored in any cycle where start_timer = 1 (stale-pulse guard).
//  ARMED: driver_door -> TRIGGERED, start driver delay. Else passenger_door -> TRIGGERED,
//   start passenger delay. Driver door wins if both doors open together.
//  TRIGGERED: ignition -> DISARMED. Else expired -> SOUND_ALARM.
//  SOUND_ALARM: ignition -> DISARMED. Else both doors closed -> ALARM_HOLD, start alarm time.
//  ALARM_HOLD: ignition -> DISARMED. Else either door open -> SOUND_ALARM.
//   Else expired -> ARMED. Door open beats a simultaneous expired.
//  DISARMED: ~ignition -> WAIT_DOOR_OPEN.
//  WAIT_DOOR_OPEN: ignition -> DISARMED. Else driver_door -> WAIT_DOOR_CLOSE.
//  WAIT_DOOR_CLOSE: ignition -> DISARMED. Else ~driver_door -> ARM_DELAY, start arm time.
//  ARM_DELAY: ignition -> DISARMED. Else any door open -> WAIT_DOOR_CLOSE.
//   Else expired -> ARMED.
//  Priority in every state: reprogram > ignition > door > expired.
//  reprogram: if prog_we, time[prog_sel] <= prog_val. State -> ARMED, siren 0, no start pulse.
//   Any running countdown is abandoned; its later expired is ignored because ARMED ignores it.
//  Time registers are read only when a start is issued; a write mid-countdown affects the next start only.
//  siren = 1 iff next state in {SOUND_ALARM, ALARM_HOLD}; registered with the state.
//  status_led:
//   - ARMED: toggles every BLINK_HALF cycles. Counter 26-bit, wraps at BLINK_HALF-1;
//     cleared to 0 and led forced 0 on ARMED entry.
//   - TRIGGERED, SOUND_ALARM, ALARM_HOLD: steady 1.
//   - All other states: 0.
//  Zero time: the timer expires immediately, so the FSM advances on the first post-guard expired.
// TESTING (bench uses BLINK_HALF = 4 and a behavioural timer, 1 s = 8 clks)
//  1. Reset, driver_door=1 for 1 clk -> next clk start_timer=1, value=8, state 1.
//     Expired -> state 2, siren 1.
//  2. In SOUND_ALARM close doors -> start_timer with value=10, state 3.
//     Reopen passenger door before expired -> state 2. Close doors, let expire -> state 0, siren 0.
//  3. Both doors open in ARMED in the same clk -> value=8, not 15.
//     Ignition during TRIGGERED -> state 4, no siren.
//  4. Arm sequence: ignition off -> 5, driver open -> 6, close -> 7 with value=6.
//     Door reopen -> 6. Close, expire -> 0; status_led toggles every 4 clks.
//  5. reprogram, prog_we=1, sel=1, val=3 during TRIGGERED -> state 0, siren 0.
//     Stale expired ignored. Next driver trigger loads value=3.
//  6. Assert reset mid-ALARM_HOLD -> outputs at reset values immediately (async).
//     Time registers back to 6/8/15/10.

Source files
------------

// File: rtl/alarm_fsm.sv
`default_nettype none
// alarm_fsm: vehicle anti-theft controller with four programmable delays.
// It drives an external countdown timer and produces the siren, status LED and debug state.
module alarm_fsm #(
   parameter logic [25:0] BLINK_HALF   = 26'd52_000_000,
   parameter logic [3:0]  T_ARM_DEF    = 4'd6,
   parameter logic [3:0]  T_DRIVER_DEF = 4'd8,
   parameter logic [3:0]  T_PASS_DEF   = 4'd15,
   parameter logic [3:0]  T_ALARM_DEF  = 4'd10
) (
   input  logic       clk_104mhz,
   input  logic       reset,
   input  logic       ignition,
   input  logic       driver_door,
   input  logic       passenger_door,
   input  logic       reprogram,
   input  logic       prog_we,
   input  logic [1:0] prog_sel,
   input  logic [3:0] prog_val,
   input  logic       expired,
   output logic       start_timer,
   output logic [3:0] value,
   output logic       siren,
   output logic       status_led,
   output logic [2:0] state_out
);

   localparam logic [2:0] ARMED           = 3'd0;
   localparam logic [2:0] TRIGGERED       = 3'd1;
   localparam logic [2:0] SOUND_ALARM     = 3'd2;
   localparam logic [2:0] ALARM_HOLD      = 3'd3;
   localparam logic [2:0] DISARMED        = 3'd4;
   localparam logic [2:0] WAIT_DOOR_OPEN  = 3'd5;
   localparam logic [2:0] WAIT_DOOR_CLOSE = 3'd6;
   localparam logic [2:0] ARM_DELAY       = 3'd7;

   logic [2:0]  state;
   logic [2:0]  next_state;
   logic [3:0]  t_arm;
   logic [3:0]  t_drv;
   logic [3:0]  t_pass;
   logic [3:0]  t_alarm;
   logic [25:0] blink_cnt;
   logic [25:0] blink_next;
   logic        start_next;
   logic [3:0]  value_next;
   logic        siren_next;
   logic        led_next;
   logic        exp_ok;
   logic        door_open;

   // An expired pulse coinciding with our own start pulse belongs to the previous countdown.
   assign exp_ok    = expired & ~start_timer;
   assign door_open = driver_door | passenger_door;
   assign state_out = state;

   always_ff @(posedge clk_104mhz or posedge reset) begin
      if (reset) begin
         state       <= ARMED;
         start_timer <= 1'b0;
         value       <= 4'd0;
         siren       <= 1'b0;
         status_led  <= 1'b0;
         blink_cnt   <= 26'd0;
      end else begin
         state       <= next_state;
         start_timer <= start_next;
         value       <= value_next;
         siren       <= siren_next;
         status_led  <= led_next;
         blink_cnt   <= blink_next;
      end
   end

   always_ff @(posedge clk_104mhz or posedge reset) begin
      if (reset) begin
         t_arm   <= T_ARM_DEF;
         t_drv   <= T_DRIVER_DEF;
         t_pass  <= T_PASS_DEF;
         t_alarm <= T_ALARM_DEF;
      end else if (reprogram && prog_we) begin
         case (prog_sel)
            2'd0:    t_arm   <= prog_val;
            2'd1:    t_drv   <= prog_val;
            2'd2:    t_pass  <= prog_val;
            default: t_alarm <= prog_val;
         endcase
      end
   end

   always_comb begin
      next_state = state;
      start_next = 1'b0;
      value_next = value;
      if (reprogram) begin
         next_state = ARMED;
      end else begin
         case (state)
            ARMED: begin
               if (driver_door) begin
                  next_state = TRIGGERED;
                  start_next = 1'b1;
                  value_next = t_drv;
               end else if (passenger_door) begin
                  next_state = TRIGGERED;
                  start_next = 1'b1;
                  value_next = t_pass;
               end
            end
            TRIGGERED: begin
               if (ignition)    next_state = DISARMED;
               else if (exp_ok) next_state = SOUND_ALARM;
            end
            SOUND_ALARM: begin
               if (ignition) begin
                  next_state = DISARMED;
               end else if (!door_open) begin
                  next_state = ALARM_HOLD;
                  start_next = 1'b1;
                  value_next = t_alarm;
               end
            end
            ALARM_HOLD: begin
               if (ignition)       next_state = DISARMED;
               else if (door_open) next_state = SOUND_ALARM;
               else if (exp_ok)    next_state = ARMED;
            end
            DISARMED: begin
               if (!ignition) next_state = WAIT_DOOR_OPEN;
            end
            WAIT_DOOR_OPEN: begin
               if (ignition)         next_state = DISARMED;
               else if (driver_door) next_state = WAIT_DOOR_CLOSE;
            end
            WAIT_DOOR_CLOSE: begin
               if (ignition) begin
                  next_state = DISARMED;
               end else if (!driver_door) begin
                  next_state = ARM_DELAY;
                  start_next = 1'b1;
                  value_next = t_arm;
               end
            end
            ARM_DELAY: begin
               if (ignition)       next_state = DISARMED;
               else if (door_open) next_state = WAIT_DOOR_CLOSE;
               else if (exp_ok)    next_state = ARMED;
            end
            default: next_state = ARMED;
         endcase
      end
   end

   always_comb begin
      siren_next = (next_state == SOUND_ALARM) || (next_state == ALARM_HOLD);
      blink_next = 26'd0;
      led_next   = 1'b0;
      if (next_state == ARMED) begin
         // Entering ARMED (including via reprogram) restarts the blink phase with the LED off.
         if ((state != ARMED) || reprogram) begin
            blink_next = 26'd0;
            led_next   = 1'b0;
         end else if (blink_cnt == BLINK_HALF - 26'd1) begin
            blink_next = 26'd0;
            led_next   = ~status_led;
         end else begin
            blink_next = blink_cnt + 26'd1;
            led_next   = status_led;
         end
      end else begin
         led_next = (next_state == TRIGGERED) || (next_state == SOUND_ALARM) ||
                    (next_state == ALARM_HOLD);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alarm_fsm.sv
`default_nettype none
// tb_alarm_fsm: directed scenarios with a behavioural timer (1 s = 8 clks) and
// scoreboard queues checked by monitors on the falling clock edge.
module tb_alarm_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       ignition, driver_door, passenger_door;
   logic       reprogram, prog_we;
   logic [1:0] prog_sel;
   logic [3:0] prog_val;
   logic       expired;
   logic       start_timer;
   logic [3:0] value;
   logic       siren, status_led;
   logic [2:0] state_out;

   logic       tmr_exp;
   logic       inj_exp;
   logic       tmr_run;
   int         tmr_cnt;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct {
      string      name;
      logic [2:0] st;
      logic       sir;
      int         led;      // -1 = don't care
      bit         rst_chk;
   } exp_t;

   typedef struct {
      string      name;
      logic [3:0] val;
      logic [2:0] st;
   } start_t;

   exp_t   exp_q[$];
   start_t start_q[$];

   always #5 clk = ~clk;

   assign expired = tmr_exp | inj_exp;

   alarm_fsm #(.BLINK_HALF(26'd4)) dut (
      .clk_104mhz     (clk),
      .reset          (reset),
      .ignition       (ignition),
      .driver_door    (driver_door),
      .passenger_door (passenger_door),
      .reprogram      (reprogram),
      .prog_we        (prog_we),
      .prog_sel       (prog_sel),
      .prog_val       (prog_val),
      .expired        (expired),
      .start_timer    (start_timer),
      .value          (value),
      .siren          (siren),
      .status_led     (status_led),
      .state_out      (state_out)
   );

   // Behavioural countdown timer: reloads on every start, zero expires on the next cycle.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         tmr_exp <= 1'b0;
         tmr_run <= 1'b0;
         tmr_cnt <= 0;
      end else begin
         tmr_exp <= 1'b0;
         if (start_timer) begin
            tmr_cnt <= int'(value) * 8;
            tmr_run <= 1'b1;
         end else if (tmr_run) begin
            if (tmr_cnt == 0) begin
               tmr_exp <= 1'b1;
               tmr_run <= 1'b0;
            end else begin
               tmr_cnt <= tmr_cnt - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      bit   bad;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         bad = (state_out !== e.st) || (siren !== e.sir) ||
               ((e.led >= 0) && (status_led !== e.led[0])) ||
               (e.rst_chk && ((start_timer !== 1'b0) || (value !== 4'd0)));
         if (bad) begin
            miscompares++;
            $display("FAIL %s: got state=%0d siren=%b led=%b start=%b value=%0d, want state=%0d siren=%b led=%0d",
                     e.name, state_out, siren, status_led, start_timer, value, e.st, e.sir, e.led);
         end
      end
   end

   always @(negedge clk) begin
      start_t s;
      if (start_timer === 1'b1) begin
         vectors++;
         if (start_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_start: got start value=%0d state=%0d, want no start", value, state_out);
         end else begin
            s = start_q.pop_front();
            if ((value !== s.val) || (state_out !== s.st)) begin
               miscompares++;
               $display("FAIL %s: got value=%0d state=%0d, want value=%0d state=%0d",
                        s.name, value, state_out, s.val, s.st);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [2:0] st, input logic sir, input int led,
                      input bit rc = 1'b0);
      exp_t e;
      e.name = n; e.st = st; e.sir = sir; e.led = led; e.rst_chk = rc;
      exp_q.push_back(e);
   endtask

   task automatic push_start(input string n, input logic [3:0] v, input logic [2:0] st);
      start_t s;
      s.name = n; s.val = v; s.st = st;
      start_q.push_back(s);
   endtask

   task automatic wait_exp(input string n, input int max_cycles);
      int k = 0;
      while (!tmr_exp && k < max_cycles) begin
         step();
         k++;
      end
      if (!tmr_exp) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: got no expired within %0d cycles, want timer expiry", n, max_cycles);
      end
   endtask

   initial begin
      reset = 1'b1; ignition = 1'b0; driver_door = 1'b0; passenger_door = 1'b0;
      reprogram = 1'b0; prog_we = 1'b0; prog_sel = 2'd0; prog_val = 4'd0; inj_exp = 1'b0;
      step(); step();
      chk("reset_state", 3'd0, 1'b0, 0, 1'b1);
      reset = 1'b0;
      step();

      // Driver trigger, expiry into SOUND_ALARM
      driver_door = 1'b1;
      push_start("drv_start", 4'd8, 3'd1);
      step();
      chk("triggered", 3'd1, 1'b0, 1);
      wait_exp("t1_exp", 200);
      step();
      chk("sound_alarm", 3'd2, 1'b1, 1);

      // Close -> ALARM_HOLD; stale expired during start cycle ignored
      driver_door = 1'b0;
      push_start("alarm_start", 4'd10, 3'd3);
      step();
      chk("alarm_hold", 3'd3, 1'b1, 1);
      inj_exp = 1'b1;
      step();
      inj_exp = 1'b0;
      chk("guard_stale", 3'd3, 1'b1, 1);
      step();
      // Door reopen beats a simultaneous expired
      passenger_door = 1'b1;
      inj_exp = 1'b1;
      step();
      inj_exp = 1'b0;
      chk("door_beats_exp", 3'd2, 1'b1, 1);
      passenger_door = 1'b0;
      push_start("alarm_restart", 4'd10, 3'd3);
      step();
      chk("alarm_hold2", 3'd3, 1'b1, 1);
      wait_exp("t2_exp", 200);
      step();
      chk("hold_to_armed", 3'd0, 1'b0, 0);

      // Both doors together: driver delay wins; ignition disarms
      driver_door = 1'b1; passenger_door = 1'b1;
      push_start("both_doors", 4'd8, 3'd1);
      step();
      chk("both_trig", 3'd1, 1'b0, 1);
      driver_door = 1'b0; passenger_door = 1'b0; ignition = 1'b1;
      step();
      chk("disarmed", 3'd4, 1'b0, 0);

      // Arm sequence
      ignition = 1'b0;
      step();
      chk("wait_open", 3'd5, 1'b0, 0);
      driver_door = 1'b1;
      step();
      chk("wait_close", 3'd6, 1'b0, 0);
      driver_door = 1'b0;
      push_start("arm_start", 4'd6, 3'd7);
      step();
      chk("arm_delay", 3'd7, 1'b0, 0);
      passenger_door = 1'b1;
      step();
      chk("arm_reopen", 3'd6, 1'b0, 0);
      passenger_door = 1'b0;
      push_start("arm_restart", 4'd6, 3'd7);
      step();
      chk("arm_delay2", 3'd7, 1'b0, 0);
      wait_exp("t4_exp", 200);
      step();
      chk("armed_entry", 3'd0, 1'b0, 0);
      repeat (3) step();
      chk("blink_pre", 3'd0, 1'b0, 0);
      step();
      chk("blink_on", 3'd0, 1'b0, 1);
      repeat (3) step();
      chk("blink_hold", 3'd0, 1'b0, 1);
      step();
      chk("blink_off", 3'd0, 1'b0, 0);

      // Reprogram driver delay during TRIGGERED
      driver_door = 1'b1;
      push_start("drv_start2", 4'd8, 3'd1);
      step();
      chk("triggered2", 3'd1, 1'b0, 1);
      driver_door = 1'b0;
      repeat (4) step();
      reprogram = 1'b1; prog_we = 1'b1; prog_sel = 2'd1; prog_val = 4'd3;
      step();
      reprogram = 1'b0; prog_we = 1'b0;
      chk("reprog_armed", 3'd0, 1'b0, 0);
      wait_exp("t5_stale", 200);
      step();
      chk("stale_ignored", 3'd0, 1'b0, -1);
      driver_door = 1'b1;
      push_start("drv_prog3", 4'd3, 3'd1);
      step();
      chk("triggered3", 3'd1, 1'b0, 1);

      // Async reset mid-ALARM_HOLD
      wait_exp("t6_exp", 200);
      step();
      chk("sound_alarm3", 3'd2, 1'b1, 1);
      driver_door = 1'b0;
      push_start("alarm_start3", 4'd10, 3'd3);
      step();
      chk("alarm_hold3", 3'd3, 1'b1, 1);
      repeat (3) step();
      reset = 1'b1;
      #2;
      chk("async_reset", 3'd0, 1'b0, 0, 1'b1);
      step(); step();
      reset = 1'b0;
      step();
      driver_door = 1'b1;
      push_start("rst_drv", 4'd8, 3'd1);
      step();
      driver_door = 1'b0;
      reprogram = 1'b1;
      step();
      reprogram = 1'b0;
      chk("reprog_no_we", 3'd0, 1'b0, 0);
      passenger_door = 1'b1;
      push_start("rst_pass", 4'd15, 3'd1);
      step();
      passenger_door = 1'b0; ignition = 1'b1;
      step();
      ignition = 1'b0;
      step();
      driver_door = 1'b1;
      step();
      driver_door = 1'b0;
      push_start("rst_arm", 4'd6, 3'd7);
      step();
      chk("rst_arm_state", 3'd7, 1'b0, 0);
      step(); step();

      vectors++;
      if (start_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_start: got %0d starts outstanding, want 0", start_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
